// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared definitions for the stream_mux_rr slice.
//   MODE_FIXED / MODE_RR : encodings of the top-level `mode` input.
//   idx_w(n)             : width of a channel index (out_ch, s, ptr) for n channels.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index width; a single-bit index is kept even for degenerate n.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req_i     : request vector, one bit per channel
//   ptr_i     : highest-priority channel; search runs upward from here and wraps
//   gnt_o     : one-hot grant (all zero when nothing requests)
//   gnt_idx_o : index of the granted channel (0 when nothing requests)
//   gnt_vld_o : a grant exists
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int IW   = idx_w(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            gnt_vld_o
);

    localparam logic [IW:0] NCH_W = (IW+1)'(N_CH);

    logic [IW:0] cand_s;

    // First requester at or above ptr, wrapping; one extra bit keeps ptr+i from overflowing.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand_s    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand_s = {1'b0, ptr_i} + (IW+1)'(i);
            if (cand_s >= NCH_W) begin
                cand_s = cand_s - NCH_W;
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_vld_o && req_i[cand_s[IW-1:0]]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = cand_s[IW-1:0];
            end else begin
                gnt_vld_o = gnt_vld_o;
            end
        end
    end

    // Expand the winning index into a one-hot grant.
    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            gnt_o[k] = gnt_vld_o && (gnt_idx_o == IW'(k));
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a registered
// output stage and fixed-select or round-robin arbitration.
//   in_data/in_valid/in_last/in_ready : N_CH producer ports (channel k data at [k*WIDTH +: WIDTH])
//   mode, s                           : 0 = fixed select on s, 1 = round-robin
//   out_data/out_valid/out_last/out_ch/out_ready : single registered consumer port
// Optional feature: define STREAM_MUX_PKT_EN to hold the grant on one channel
// from the first beat of a packet until the beat carrying in_last.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int IW    = idx_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [IW-1:0]         s,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [IW-1:0]         out_ch,
    input  logic                  out_ready
);

    localparam logic [IW:0]   NCH_W   = (IW+1)'(N_CH);
    localparam logic [IW-1:0] LAST_CH = IW'(N_CH - 1);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q,  out_last_d;
    logic [IW-1:0]    out_ch_q,    out_ch_d;
    logic [IW-1:0]    ptr_q,       ptr_d;
`ifdef STREAM_MUX_PKT_EN
    logic             lock_q,      lock_d;
    logic [IW-1:0]    lock_ch_q,   lock_ch_d;
`endif

    logic [N_CH-1:0]  rr_gnt_s;
    logic [IW-1:0]    rr_idx_s;
    logic             rr_vld_s;
    logic [N_CH-1:0]  g_oh_s;
    logic [IW-1:0]    g_idx_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic             accept_s;
    logic             in_xfer_s;
    logic [IW-1:0]    ptr_next_s;

    rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
        .req_i     (in_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (rr_gnt_s),
        .gnt_idx_o (rr_idx_s),
        .gnt_vld_o (rr_vld_s)
    );

    // Grant selection: packet lock wins, then RR or fixed select (out-of-range s grants nothing).
    always_comb begin
        g_oh_s  = '0;
        g_idx_s = s;
`ifdef STREAM_MUX_PKT_EN
        if (lock_q) begin
            g_idx_s = lock_ch_q;
            for (int k = 0; k < N_CH; k++) begin
                g_oh_s[k] = (lock_ch_q == IW'(k));
            end
        end else
`endif
        if (mode == MODE_RR) begin
            g_idx_s = rr_idx_s;
            g_oh_s  = rr_gnt_s & {N_CH{rr_vld_s}};
        end else begin
            g_idx_s = s;
            for (int k = 0; k < N_CH; k++) begin
                g_oh_s[k] = ({1'b0, s} < NCH_W) && (s == IW'(k));
            end
        end
    end

    // Granted channel's payload; the one-hot mask avoids indexing past N_CH.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (g_oh_s[k]) begin
                sel_data_s = in_data[k*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    assign sel_valid_s = |(g_oh_s & in_valid);
    assign sel_last_s  = |(g_oh_s & in_last);
    // Output slot is free when empty or being drained this cycle.
    assign accept_s    = !out_valid_q || out_ready;
    assign in_ready    = g_oh_s & {N_CH{accept_s}};
    assign in_xfer_s   = sel_valid_s && accept_s;
    assign ptr_next_s  = (g_idx_s == LAST_CH) ? '0 : (g_idx_s + IW'(1));

    // Next-state for the output register, RR pointer and packet lock.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
`ifdef STREAM_MUX_PKT_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (in_xfer_s) begin
            out_data_d  = sel_data_s;
            out_valid_d = 1'b1;
            out_last_d  = sel_last_s;
            out_ch_d    = g_idx_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
`ifdef STREAM_MUX_PKT_EN
        // Pointer moves only when a packet ends, so a packet counts as one turn.
        if (in_xfer_s && (mode == MODE_RR) && sel_last_s) begin
`else
        if (in_xfer_s && (mode == MODE_RR)) begin
`endif
            ptr_d = ptr_next_s;
        end else begin
            ptr_d = ptr_q;
        end
`ifdef STREAM_MUX_PKT_EN
        if (in_xfer_s) begin
            lock_d    = !sel_last_s;
            lock_ch_d = g_idx_s;
        end else begin
            lock_d    = lock_q;
        end
`endif
    end

    // State registers; asynchronous reset drops any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
`ifdef STREAM_MUX_PKT_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_PKT_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule
